// File: rtl/decode_ctrl_stage.sv
// ID-stage opcode decoder registered into the ID/EX boundary.
// The decoded control bundle is captured with stall/flush control, and illegal
// opcodes are flagged.
// Optional feature macro: ILLEGAL_CNT_EN builds the saturating illegal-opcode
// counter. When the macro is undefined, illegal_cnt is tied to 0.
module decode_ctrl_stage #(
  parameter int unsigned EXT_U    = 1,
  parameter int unsigned EXT_JALR = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_d,
  input  logic [6:0]       op_d,
  input  logic             stall_e,
  input  logic             flush_e,
  output logic             valid_e,
  output logic             RegWrite_e,
  output logic [2:0]       ImmSrc_e,
  output logic             ALUSrc_e,
  output logic [1:0]       ALUSrcA_e,
  output logic             MemWrite_e,
  output logic [1:0]       ResultSrc_e,
  output logic             Branch_e,
  output logic [1:0]       ALUOp_e,
  output logic             Jump_e,
  output logic             JumpReg_e,
  output logic             illegal_e,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       jump_reg;
    logic [1:0] alu_src_a;
  } ctrl_t;

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  logic  load;

  ctrl_t ctrl_e_d, ctrl_e_q;
  logic  valid_e_d, valid_e_q;
  logic  illegal_e_d, illegal_e_q;

  // Opcode to control bundle; anything unrecognised is illegal with all controls low.
  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    unique case (op_d)
      7'b0000011: dec_ctrl = 15'b1_000_1_0_01_0_00_0_0_00;
      7'b0100011: dec_ctrl = 15'b0_001_1_1_00_0_00_0_0_00;
      7'b0110011: dec_ctrl = 15'b1_000_0_0_00_0_10_0_0_00;
      7'b1100011: dec_ctrl = 15'b0_010_0_0_00_1_01_0_0_00;
      7'b0010011: dec_ctrl = 15'b1_000_1_0_00_0_11_0_0_00;
      7'b1101111: dec_ctrl = 15'b1_011_0_0_10_0_00_1_0_00;
      7'b1100111: begin
        if (EXT_JALR != 0) dec_ctrl = 15'b1_000_1_0_10_0_00_1_1_00;
        else               dec_illegal = 1'b1;
      end
      7'b0110111: begin
        if (EXT_U != 0) dec_ctrl = 15'b1_100_1_0_00_0_00_0_0_10;
        else            dec_illegal = 1'b1;
      end
      7'b0010111: begin
        if (EXT_U != 0) dec_ctrl = 15'b1_100_1_0_00_0_00_0_0_01;
        else            dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign load = !flush_e && !stall_e && valid_d;

  // ID/EX next state: flush beats stall, stall holds, otherwise load or bubble.
  always_comb begin
    valid_e_d   = valid_e_q;
    ctrl_e_d    = ctrl_e_q;
    illegal_e_d = illegal_e_q;
    if (flush_e || (!stall_e && !valid_d)) begin
      valid_e_d   = 1'b0;
      ctrl_e_d    = '0;
      illegal_e_d = 1'b0;
    end else if (load) begin
      valid_e_d   = 1'b1;
      ctrl_e_d    = dec_ctrl;
      illegal_e_d = dec_illegal;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_e_q   <= 1'b0;
      ctrl_e_q    <= '0;
      illegal_e_q <= 1'b0;
    end else begin
      valid_e_q   <= valid_e_d;
      ctrl_e_q    <= ctrl_e_d;
      illegal_e_q <= illegal_e_d;
    end
  end

`ifdef ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Count only illegal instructions actually loaded; saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (load && dec_illegal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Illegal-opcode counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign illegal_cnt = cnt_q;
`else
  assign illegal_cnt = '0;
`endif

  assign valid_e     = valid_e_q;
  assign illegal_e   = illegal_e_q;
  assign RegWrite_e  = ctrl_e_q.reg_write;
  assign ImmSrc_e    = ctrl_e_q.imm_src;
  assign ALUSrc_e    = ctrl_e_q.alu_src;
  assign MemWrite_e  = ctrl_e_q.mem_write;
  assign ResultSrc_e = ctrl_e_q.result_src;
  assign Branch_e    = ctrl_e_q.branch;
  assign ALUOp_e     = ctrl_e_q.alu_op;
  assign Jump_e      = ctrl_e_q.jump;
  assign JumpReg_e   = ctrl_e_q.jump_reg;
  assign ALUSrcA_e   = ctrl_e_q.alu_src_a;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Randomized bench for decode_ctrl_stage.
// One instance uses the default parameters. The other has EXT_U=0, EXT_JALR=0 and CNT_W=2.
// Both instances are compared against a table-driven reference model.
module tb_decode_ctrl_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_d;
  logic [6:0] op_d;
  logic       stall_e;
  logic       flush_e;

  logic       valid_a, regw_a, alus_a, memw_a, br_a, jmp_a, jr_a, ill_a;
  logic [2:0] imm_a;
  logic [1:0] alusa_a, res_a, aluop_a;
  logic [7:0] cnt_a;

  logic       valid_b, regw_b, alus_b, memw_b, br_b, jmp_b, jr_b, ill_b;
  logic [2:0] imm_b;
  logic [1:0] alusa_b, res_b, aluop_b;
  logic [1:0] cnt_b;

  int n_total = 0;
  int n_bad   = 0;

  // Expected architectural state per instance: index 0 = default, 1 = restricted.
  logic [14:0] exp_ctrl [2];
  logic        exp_valid[2];
  logic        exp_ill  [2];
  int          exp_cnt  [2];
  int          cnt_max  [2] = '{255, 3};
  bit          ext_on   [2] = '{1'b1, 1'b0};

  logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  always #5 clk = ~clk;

  decode_ctrl_stage u_dut_a (
    .clk(clk), .reset(reset), .valid_d(valid_d), .op_d(op_d), .stall_e(stall_e),
    .flush_e(flush_e), .valid_e(valid_a), .RegWrite_e(regw_a), .ImmSrc_e(imm_a),
    .ALUSrc_e(alus_a), .ALUSrcA_e(alusa_a), .MemWrite_e(memw_a), .ResultSrc_e(res_a),
    .Branch_e(br_a), .ALUOp_e(aluop_a), .Jump_e(jmp_a), .JumpReg_e(jr_a),
    .illegal_e(ill_a), .illegal_cnt(cnt_a)
  );

  decode_ctrl_stage #(.EXT_U(0), .EXT_JALR(0), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .valid_d(valid_d), .op_d(op_d), .stall_e(stall_e),
    .flush_e(flush_e), .valid_e(valid_b), .RegWrite_e(regw_b), .ImmSrc_e(imm_b),
    .ALUSrc_e(alus_b), .ALUSrcA_e(alusa_b), .MemWrite_e(memw_b), .ResultSrc_e(res_b),
    .Branch_e(br_b), .ALUOp_e(aluop_b), .Jump_e(jmp_b), .JumpReg_e(jr_b),
    .illegal_e(ill_b), .illegal_cnt(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decode: {illegal, RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch,
  // ALUOp, Jump, JumpReg, ALUSrcA}, straight from the opcode table.
  function automatic logic [15:0] ref_decode(input logic [6:0] op, input bit ext);
    case (op)
      7'b0000011: return 16'b0_1_000_1_0_01_0_00_0_0_00;
      7'b0100011: return 16'b0_0_001_1_1_00_0_00_0_0_00;
      7'b0110011: return 16'b0_1_000_0_0_00_0_10_0_0_00;
      7'b1100011: return 16'b0_0_010_0_0_00_1_01_0_0_00;
      7'b0010011: return 16'b0_1_000_1_0_00_0_11_0_0_00;
      7'b1101111: return 16'b0_1_011_0_0_10_0_00_1_0_00;
      7'b1100111: return ext ? 16'b0_1_000_1_0_10_0_00_1_1_00 : 16'h8000;
      7'b0110111: return ext ? 16'b0_1_100_1_0_00_0_00_0_0_10 : 16'h8000;
      7'b0010111: return ext ? 16'b0_1_100_1_0_00_0_00_0_0_01 : 16'h8000;
      default:    return 16'h8000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_ctrl[i] = '0; exp_valid[i] = 1'b0; exp_ill[i] = 1'b0; exp_cnt[i] = 0;
    end
  endtask

  task automatic model_clock();
    logic [15:0] d;
    for (int i = 0; i < 2; i++) begin
      d = ref_decode(op_d, ext_on[i]);
      if (flush_e || (!stall_e && !valid_d)) begin
        exp_ctrl[i] = '0; exp_valid[i] = 1'b0; exp_ill[i] = 1'b0;
      end else if (!stall_e) begin
        exp_ctrl[i] = d[14:0]; exp_valid[i] = 1'b1; exp_ill[i] = d[15];
        if (d[15] && exp_cnt[i] < cnt_max[i]) exp_cnt[i]++;
      end
    end
  endtask

  function automatic int cnt_expect(input int i);
`ifdef ILLEGAL_CNT_EN
    return exp_cnt[i];
`else
    return 0;
`endif
  endfunction

  task automatic compare_all();
    chk("a_valid", 32'(valid_a), 32'(exp_valid[0]));
    chk("a_bundle", 32'({regw_a, imm_a, alus_a, memw_a, res_a, br_a, aluop_a, jmp_a, jr_a,
                         alusa_a}), 32'(exp_ctrl[0]));
    chk("a_illegal", 32'(ill_a), 32'(exp_ill[0]));
    chk("a_cnt", 32'(cnt_a), 32'(cnt_expect(0)));
    chk("b_valid", 32'(valid_b), 32'(exp_valid[1]));
    chk("b_bundle", 32'({regw_b, imm_b, alus_b, memw_b, res_b, br_b, aluop_b, jmp_b, jr_b,
                         alusa_b}), 32'(exp_ctrl[1]));
    chk("b_illegal", 32'(ill_b), 32'(exp_ill[1]));
    chk("b_cnt", 32'(cnt_b), 32'(cnt_expect(1)));
  endtask

  // Inputs are set while clk is low; one rising edge, then check 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic st, input logic fl);
    valid_d = v; op_d = op; stall_e = st; flush_e = fl;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 7'b0110011, 1'b0, 1'b0);
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
    step();  // R-type appears one cycle after reset release

    // Back-to-back legal opcodes.
    foreach (legal_ops[i]) begin
      drive(1'b1, legal_ops[i], 1'b0, 1'b0);
      step();
    end

    // Branch, then hold three cycles with a load on op_d, then release.
    drive(1'b1, 7'b1100011, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7'b0000011, 1'b1, 1'b0);
      step();
    end
    drive(1'b1, 7'b0000011, 1'b0, 1'b0);
    step();

    // Flush together with stall and an illegal opcode.
    drive(1'b1, 7'b1111111, 1'b1, 1'b1);
    step();

    // Five consecutive illegal opcodes: restricted instance saturates at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i % 2 == 0) ? 7'b0110111 : 7'b1111111, 1'b0, 1'b0);
      step();
    end

    // Asynchronous reset in the middle of a cycle.
    drive(1'b1, 7'b0000000, 1'b0, 1'b0);
    step();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 3) == 0) ? 7'($urandom)
            : legal_ops[$urandom_range(0, 8)], ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
Parametrised, registered successor to the single-cycle opcode decoder. Decodes the ID-stage opcode into a widened control bundle with RV32I coverage of JALR, LUI and AUIPC, selectable via parameters. Flags illegal opcodes and captures the bundle into the ID/EX pipeline boundary with stall/flush control. Sits between the ID stage and the EX-stage datapath; the hazard unit drives stall/flush.

Parameters:
EXT_U, 1, 1 = decode LUI/AUIPC; 0 = treat them as illegal.
EXT_JALR, 1, 1 = decode JALR; 0 = treat it as illegal.
CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
valid_d  in  1  ID stage holds a real instruction
op_d  in  7  opcode, instr[6:0]
stall_e  in  1  hold the ID/EX register
flush_e  in  1  insert a bubble into the ID/EX register
valid_e  out  1  EX-stage control bundle is valid
RegWrite_e  out  1  register write enable
ImmSrc_e  out  3  000 I, 001 S, 010 B, 011 J, 100 U
ALUSrc_e  out  1  ALU operand B: 0 rs2, 1 immediate
ALUSrcA_e  out  2  ALU operand A: 00 rs1, 01 PC, 10 zero
MemWrite_e  out  1  store enable
ResultSrc_e  out  2  00 ALU, 01 memory, 10 PC+4
Branch_e  out  1  conditional branch
ALUOp_e  out  2  00 add, 01 branch compare, 10 R-funct, 11 I-funct
Jump_e  out  1  unconditional jump
JumpReg_e  out  1  jump target from rs1+imm (JALR)
illegal_e  out  1  valid instruction with an unsupported opcode
illegal_cnt  out  CNT_W  saturating count of illegal opcodes

Behaviour:
- Reset, asynchronous: every output and illegal_cnt = 0.
- Combinational decode. Every don't-care is resolved to 0. Field order is RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump, JumpReg, ALUSrcA:
  0000011 load: 1 000 1 0 01 0 00 0 0 00
  0100011 store: 0 001 1 1 00 0 00 0 0 00
  0110011 R-type: 1 000 0 0 00 0 10 0 0 00
  1100011 branch: 0 010 0 0 00 1 01 0 0 00
  0010011 I-ALU: 1 000 1 0 00 0 11 0 0 00
  1101111 JAL: 1 011 0 0 10 0 00 1 0 00
  1100111 JALR (EXT_JALR=1): 1 000 1 0 10 0 00 1 1 00
  0110111 LUI (EXT_U=1): 1 100 1 0 00 0 00 0 0 10
  0010111 AUIPC (EXT_U=1): 1 100 1 0 00 0 00 0 0 01
  Any other opcode, including op_d[1:0] != 11 or a parameter-disabled opcode: all controls 0 and illegal = 1.
- Register update on each rising clk, in priority order:
  1. flush_e = 1: bubble. valid_e = 0 and all controls and illegal_e = 0. Flush overrides stall.
  2. stall_e = 1: all _e outputs hold their values.
  3. Otherwise, if valid_d = 1: load the decoded bundle, valid_e = 1, and illegal_e = decoded illegal flag.
  4. Otherwise (valid_d = 0): bubble.
- Latency: exactly 1 cycle from op_d to the _e outputs.
- illegal_cnt increments by 1 only on a case-3 load with illegal = 1. It saturates at 2^CNT_W-1 and does not wrap.
  - No increment on stall hold, on flush, or when valid_d = 0.
  - Flush and illegal in the same cycle: flush wins, no count.
- Reset asserted mid-stream clears the register and the counter immediately, without waiting for clk. First load occurs on the first rising edge after reset deasserts.
- An illegal instruction is never given RegWrite or MemWrite, so it cannot modify architectural state.

Optional Feature:
ILLEGAL_CNT_EN
- Defined: illegal_cnt behaves as described above.
- Undefined: the counter logic is not built; illegal_cnt is tied to 0. illegal_e still functions and the port list is unchanged.

Test Plan:
- reset=1 with op_d=0110011, valid_d=1 -> all outputs 0. Deassert reset, 1 clk -> RegWrite_e=1, ALUOp_e=10, valid_e=1, illegal_e=0.
- Back-to-back load, store, branch, JAL, JALR, LUI, AUIPC (all parameters at default) -> each bundle appears exactly 1 cycle later and matches its table row bit-exact.
- op_d=1100011 loaded, then stall_e=1 for 3 cycles while op_d=0000011 -> Branch_e=1 held for all 3 cycles. Release stall -> ResultSrc_e=01 on the next cycle.
- stall_e=1 and flush_e=1 together with op_d=1111111 -> valid_e=0, illegal_e=0, illegal_cnt unchanged.
- EXT_U=0 with op_d=0110111 and valid_d=1 -> illegal_e=1, RegWrite_e=0, illegal_cnt goes 0 -> 1.
- CNT_W=2 with 5 consecutive valid illegal opcodes -> illegal_cnt sequence 1, 2, 3, 3, 3. Without ILLEGAL_CNT_EN -> illegal_cnt=0 throughout while illegal_e=1.
